// File: rtl/fetch_unit.sv
// Program counter and fetch control for a 1-cycle-latency synchronous instruction memory.
// Presents a valid instruction/PC pair to decode, with stall hold, redirect squash and a misalignment fault.
module fetch_unit #(
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] addr_instr_mem,
  output logic              instruct_en,
  input  logic [31:0]       instruction,
  output logic [31:0]       instr_out,
  output logic [31:0]       pc_out,
  output logic [31:0]       pc_plus4,
  output logic              instr_valid,
  output logic              misalign_fault,
  output logic [31:0]       fetch_cnt
);

  logic [31:0] fetch_pc;
  logic [31:0] pc_q;
  logic        valid_q;
  logic        fault_q;
  logic [31:0] cnt_q;
  logic        consume;

  // Decode takes the current instruction only on a clean, unstalled, non-redirect cycle.
  assign consume = valid_q && !stall && !redirect && !fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= 32'd0;
    end else if (!fault_q) begin
      if (consume) begin
        cnt_q <= cnt_q + 32'd1;
      end
      if (redirect) begin
        valid_q <= 1'b0;
        if (redirect_pc[1:0] != 2'b00) begin
          fault_q <= 1'b1;
        end else begin
          // Target read is issued next cycle; the wrong-path read in flight is squashed.
          fetch_pc <= redirect_pc;
        end
      end else if (!stall) begin
        pc_q     <= fetch_pc;
        valid_q  <= 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  // The memory holds its output while disabled, which keeps instr_out stable under stall.
  assign instruct_en    = !rst && !stall && !fault_q;
  assign addr_instr_mem = fetch_pc[ADDR_W+1:2];
  assign instr_out      = valid_q ? instruction : NOP;
  assign pc_out         = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign instr_valid    = valid_q;
  assign misalign_fault = fault_q;
  assign fetch_cnt      = cnt_q;

endmodule
